// File: rtl/tram_console.sv
// tram_console: character-stream console controller for the text mode RAM.
// Accepts valid/ready characters with attributes and writes {attr, char}
// glyph words into tram. Tracks the cursor, interprets LF/CR/BS/FF, and
// scrolls by advancing the ring-buffer display offset, clearing each newly
// exposed line.
// Optional build macro TRAM_CONSOLE_BS_ERASE_EN: backspace also writes a
// space at the new cursor position.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_RUN      | accepting characters, in_ready high
// S_CLR_LINE | clearing the TRAM_HRES words of the new bottom line
// S_CLR_ALL  | clearing all TOTAL words after a form feed
module tram_console #(
  parameter int WORD      = 32,
  parameter int BYTE_CNT  = 4,
  parameter int ADDRW     = 11,
  parameter int TRAM_HRES = 84,
  parameter int TRAM_VRES = 24
) (
  input  logic                clk_sys,
  input  logic                rst_sys_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [7:0]          in_char,
  input  logic [WORD-9:0]     in_attr,
  output logic [BYTE_CNT-1:0] tram_we,
  output logic [ADDRW-1:0]    tram_addr,
  output logic [WORD-1:0]     tram_din,
  output logic [ADDRW-1:0]    scroll_offs,
  output logic [ADDRW-1:0]    cur_col,
  output logic [ADDRW-1:0]    cur_row,
  output logic                busy
);

  localparam int TOTAL = TRAM_HRES * TRAM_VRES;

  // TOTAL itself may equal 2^ADDRW, so only TOTAL-based values that fit
  // in ADDRW bits are materialised.
  localparam logic [ADDRW-1:0] L_ONE     = ADDRW'(1);
  localparam logic [ADDRW-1:0] L_HRES    = ADDRW'(TRAM_HRES);
  localparam logic [ADDRW-1:0] L_HRES_M1 = ADDRW'(TRAM_HRES - 1);
  localparam logic [ADDRW-1:0] L_VRES_M1 = ADDRW'(TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] L_LAST_LB = ADDRW'(TOTAL - TRAM_HRES);
  localparam logic [ADDRW-1:0] L_TOT_M1  = ADDRW'(TOTAL - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_SP = 8'h20;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_CLR_LINE = 2'd1,
    S_CLR_ALL  = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDRW-1:0]  r_line_base, w_line_base_nxt;
  logic [ADDRW-1:0]  r_col, w_col_nxt;
  logic [ADDRW-1:0]  r_row, w_row_nxt;
  logic [ADDRW-1:0]  r_scroll, w_scroll_nxt;
  logic [ADDRW-1:0]  r_clr_addr, w_clr_addr_nxt;
  logic [ADDRW-1:0]  r_clr_left, w_clr_left_nxt;
  logic [WORD-9:0]   r_fill_attr, w_fill_attr_nxt;
  logic              r_we, w_we_nxt;
  logic [ADDRW-1:0]  r_addr, w_addr_nxt;
  logic [WORD-1:0]   r_din, w_din_nxt;

  logic              w_accept;
  logic              w_adv;
  logic              w_adv_clr_first;
  logic [ADDRW-1:0]  w_cur_addr;
  logic [ADDRW-1:0]  w_lb_adv;
  logic [ADDRW-1:0]  w_sc_adv;

  assign w_accept   = in_valid && (r_state == S_RUN);
  assign w_cur_addr = r_line_base + r_col;
  assign w_lb_adv   = (r_line_base == L_LAST_LB) ? '0 : r_line_base + L_HRES;
  assign w_sc_adv   = (r_scroll == L_LAST_LB) ? '0 : r_scroll + L_HRES;

  // State, cursor, clear counter and registered tram write port.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state     <= S_RUN;
      r_line_base <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_scroll    <= '0;
      r_clr_addr  <= '0;
      r_clr_left  <= '0;
      r_fill_attr <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_line_base <= w_line_base_nxt;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_scroll    <= w_scroll_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
      r_clr_left  <= w_clr_left_nxt;
      r_fill_attr <= w_fill_attr_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_din       <= w_din_nxt;
    end
  end

  // Next-state: character interpretation in RUN, one clear word per cycle
  // in the clear states.
  always_comb begin
    w_state_nxt     = r_state;
    w_line_base_nxt = r_line_base;
    w_col_nxt       = r_col;
    w_row_nxt       = r_row;
    w_scroll_nxt    = r_scroll;
    w_clr_addr_nxt  = r_clr_addr;
    w_clr_left_nxt  = r_clr_left;
    w_fill_attr_nxt = r_fill_attr;
    w_we_nxt        = 1'b0;
    w_addr_nxt      = r_addr;
    w_din_nxt       = r_din;
    w_adv           = 1'b0;
    w_adv_clr_first = 1'b0;

    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          case (in_char)
            CH_LF: begin
              w_col_nxt       = '0;
              w_adv           = 1'b1;
              // No char write this cycle, so the first clear word can go
              // out on the acceptance edge.
              w_adv_clr_first = 1'b1;
            end
            CH_CR: begin
              w_col_nxt = '0;
            end
            CH_BS: begin
              if (r_col != '0) begin
                w_col_nxt = r_col - L_ONE;
`ifdef TRAM_CONSOLE_BS_ERASE_EN
                w_we_nxt   = 1'b1;
                w_addr_nxt = w_cur_addr - L_ONE;
                w_din_nxt  = {in_attr, CH_SP};
`endif
              end
            end
            CH_FF: begin
              w_state_nxt     = S_CLR_ALL;
              w_scroll_nxt    = '0;
              w_line_base_nxt = '0;
              w_row_nxt       = '0;
              w_col_nxt       = '0;
              w_fill_attr_nxt = in_attr;
              w_we_nxt        = 1'b1;
              w_addr_nxt      = '0;
              w_din_nxt       = {in_attr, CH_SP};
              w_clr_addr_nxt  = L_ONE;
              w_clr_left_nxt  = L_TOT_M1;
            end
            default: begin
              w_we_nxt   = 1'b1;
              w_addr_nxt = w_cur_addr;
              w_din_nxt  = {in_attr, in_char};
              if (r_col < L_HRES_M1) begin
                w_col_nxt = r_col + L_ONE;
              end else begin
                w_col_nxt = '0;
                w_adv     = 1'b1;
              end
            end
          endcase

          if (w_adv) begin
            w_line_base_nxt = w_lb_adv;
            if (r_row < L_VRES_M1) begin
              w_row_nxt = r_row + L_ONE;
            end else begin
              w_scroll_nxt    = w_sc_adv;
              w_fill_attr_nxt = in_attr;
              w_state_nxt     = S_CLR_LINE;
              if (w_adv_clr_first) begin
                w_we_nxt       = 1'b1;
                w_addr_nxt     = w_lb_adv;
                w_din_nxt      = {in_attr, CH_SP};
                w_clr_addr_nxt = w_lb_adv + L_ONE;
                w_clr_left_nxt = L_HRES_M1;
              end else begin
                w_clr_addr_nxt = w_lb_adv;
                w_clr_left_nxt = L_HRES;
              end
            end
          end
        end
      end
      S_CLR_LINE, S_CLR_ALL: begin
        if (r_clr_left != '0) begin
          w_we_nxt       = 1'b1;
          w_addr_nxt     = r_clr_addr;
          w_din_nxt      = {r_fill_attr, CH_SP};
          w_clr_addr_nxt = r_clr_addr + L_ONE;
          w_clr_left_nxt = r_clr_left - L_ONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  assign in_ready    = (r_state == S_RUN);
  assign busy        = (r_state != S_RUN);
  assign tram_we     = {BYTE_CNT{r_we}};
  assign tram_addr   = r_addr;
  assign tram_din    = r_din;
  assign scroll_offs = r_scroll;
  assign cur_col     = r_col;
  assign cur_row     = r_row;

endmodule

// File: tb/tb_tram_console.sv
// Self-checking bench for tram_console: vector table for cursor/control
// codes, write scoreboard fed by a bench-side console model, and
// hand-written sequences for scroll, wrap, form feed and reset mid-clear.
module tb_tram_console;

  localparam int WORD  = 32;
  localparam int BC    = 4;
  localparam int ADDRW = 11;
  localparam int H     = 84;
  localparam int V     = 24;
  localparam int TOTAL = H * V;
  localparam int LIMIT = 10000;

`ifdef TRAM_CONSOLE_BS_ERASE_EN
  localparam bit BS_WR = 1'b1;
`else
  localparam bit BS_WR = 1'b0;
`endif

  logic             clk_sys = 1'b0;
  logic             rst_sys_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_char = '0;
  logic [WORD-9:0]  in_attr = '0;
  logic [BC-1:0]    tram_we;
  logic [ADDRW-1:0] tram_addr;
  logic [WORD-1:0]  tram_din;
  logic [ADDRW-1:0] scroll_offs;
  logic [ADDRW-1:0] cur_col;
  logic [ADDRW-1:0] cur_row;
  logic             busy;

  tram_console #(
    .WORD(WORD), .BYTE_CNT(BC), .ADDRW(ADDRW), .TRAM_HRES(H), .TRAM_VRES(V)
  ) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_attr(in_attr),
    .tram_we(tram_we), .tram_addr(tram_addr), .tram_din(tram_din),
    .scroll_offs(scroll_offs), .cur_col(cur_col), .cur_row(cur_row),
    .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  typedef struct {
    int          addr;
    logic [31:0] din;
  } wr_t;

  typedef struct {
    logic [7:0]  ch;
    logic [23:0] attr;
    int          exp_col;
    int          exp_row;
    bit          exp_wr;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[11];

  int checks = 0;
  int failures = 0;

  int m_col = 0, m_row = 0, m_lb = 0, m_sc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.din  = d;
    exp_q.push_back(w);
  endtask

  task automatic model_line_adv(input logic [23:0] a);
    if (m_row < V - 1) begin
      m_row++;
      m_lb = (m_lb + H) % TOTAL;
    end else begin
      m_sc = (m_sc + H) % TOTAL;
      m_lb = (m_lb + H) % TOTAL;
      for (int i = 0; i < H; i++) push(m_lb + i, {a, 8'h20});
    end
  endtask

  task automatic model_accept(input logic [7:0] c, input logic [23:0] a);
    case (c)
      8'h0A: begin m_col = 0; model_line_adv(a); end
      8'h0D: m_col = 0;
      8'h08: begin
        if (m_col > 0) begin
          m_col--;
          if (BS_WR) push(m_lb + m_col, {a, 8'h20});
        end
      end
      8'h0C: begin
        m_sc = 0; m_lb = 0; m_row = 0; m_col = 0;
        for (int i = 0; i < TOTAL; i++) push(i, {a, 8'h20});
      end
      default: begin
        push(m_lb + m_col, {a, c});
        if (m_col < H - 1) m_col++;
        else begin m_col = 0; model_line_adv(a); end
      end
    endcase
  endtask

  // Returns at posedge+1 of the accepting edge.
  task automatic send(input logic [7:0] c, input logic [23:0] a);
    int n;
    n = 0;
    in_char  = c;
    in_attr  = a;
    in_valid = 1'b1;
    while (!in_ready && n < LIMIT) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= LIMIT) begin
      chk("send_ready_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk_sys);
      model_accept(c, a);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Counts cycles with in_ready low, starting the cycle after acceptance.
  task automatic count_low(output int n);
    n = 0;
    while (!in_ready && n < LIMIT) begin
      n++;
      @(posedge clk_sys);
      #1;
    end
    if (n >= LIMIT) chk("ready_low_timeout", 0, 1);
  endtask

  int c0, nlow;
  wr_t w;

  initial begin
    vecs[0]  = '{8'h0D, 24'h000100, 0, 0, 1'b0};
    vecs[1]  = '{8'h42, 24'h000200, 1, 0, 1'b1};
    vecs[2]  = '{8'h42, 24'h000200, 2, 0, 1'b1};
    vecs[3]  = '{8'h42, 24'h000200, 3, 0, 1'b1};
    vecs[4]  = '{8'h42, 24'h000200, 4, 0, 1'b1};
    vecs[5]  = '{8'h42, 24'h000200, 5, 0, 1'b1};
    vecs[6]  = '{8'h08, 24'h000300, 4, 0, BS_WR};
    vecs[7]  = '{8'h0D, 24'h000100, 0, 0, 1'b0};
    vecs[8]  = '{8'h08, 24'h000300, 0, 0, 1'b0};
    vecs[9]  = '{8'h0A, 24'h000100, 0, 1, 1'b0};
    vecs[10] = '{8'h43, 24'h000400, 1, 1, 1'b1};

    // Continuous monitor: write scoreboard and cursor vs model.
    fork
      forever begin
        @(negedge clk_sys);
        if (tram_we != '0) begin
          chk("we_all_ones", tram_we, 4'hF);
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
            $display("  extra write addr=%0d din=%h", tram_addr, tram_din);
          end else begin
            w = exp_q.pop_front();
            chk("wr_addr", tram_addr, w.addr);
            chk("wr_din", tram_din, w.din);
          end
        end
        chk("mon_col", cur_col, m_col);
        chk("mon_row", cur_row, m_row);
        chk("mon_scroll", scroll_offs, m_sc);
      end
    join_none

    // Reset values.
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_we", tram_we, 0);
    chk("rst_addr", tram_addr, 0);
    chk("rst_din", tram_din, 0);
    chk("rst_scroll", scroll_offs, 0);
    chk("rst_col", cur_col, 0);
    chk("rst_row", cur_row, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);

    // First write latency.
    send(8'h41, 24'h000F00);
    chk("A_we", tram_we, 4'hF);
    chk("A_addr", tram_addr, 0);
    chk("A_din", tram_din, 32'h000F0041);
    chk("A_col", cur_col, 1);

    // Control-code vectors.
    for (int i = 0; i < 11; i++) begin
      send(vecs[i].ch, vecs[i].attr);
      @(negedge clk_sys);
      chk($sformatf("vec%0d_col", i), cur_col, vecs[i].exp_col);
      chk($sformatf("vec%0d_row", i), cur_row, vecs[i].exp_row);
      chk($sformatf("vec%0d_wr", i), (tram_we != '0), vecs[i].exp_wr);
    end

    // Form feed from mid-screen.
    send(8'h0C, 24'h000700);
    count_low(nlow);
    chk("ff_low_cycles", nlow, TOTAL);
    @(negedge clk_sys);
    chk("ff_scroll", scroll_offs, 0);
    chk("ff_col", cur_col, 0);
    chk("ff_row", cur_row, 0);
    chk("ff_busy", busy, 0);
    chk("ff_ready", in_ready, 1);

    // One full line back-to-back.
    c0 = cyc;
    for (int i = 0; i < H; i++) send(8'h41 + 8'(i % 26), 24'h000A00);
    chk("line_cycles", cyc - c0, H);
    chk("line_col", cur_col, 0);
    chk("line_row", cur_row, 1);

    // LFs down to the last row with no stall.
    c0 = cyc;
    for (int i = 0; i < V - 2; i++) send(8'h0A, 24'h000B00);
    chk("lf_cycles", cyc - c0, V - 2);
    chk("lf_row", cur_row, V - 1);

    // First scroll.
    send(8'h0A, 24'h000C00);
    chk("scr1_we", tram_we, 4'hF);
    chk("scr1_addr", tram_addr, 0);
    chk("scr1_din", tram_din, 32'h000C0020);
    count_low(nlow);
    chk("scr1_low", nlow, H);
    chk("scr1_scroll", scroll_offs, H);
    chk("scr1_row", cur_row, V - 1);

    // Scroll until offset reaches the last line base.
    for (int i = 0; i < V - 2; i++) begin
      send(8'h0A, 24'h000D00);
      count_low(nlow);
      chk("scrN_low", nlow, H);
    end
    chk("scrN_scroll", scroll_offs, TOTAL - H);

    // Wrap of the display offset.
    send(8'h0A, 24'h000E00);
    chk("wrap_addr", tram_addr, TOTAL - H);
    count_low(nlow);
    chk("wrap_low", nlow, H);
    chk("wrap_scroll", scroll_offs, 0);

    // Printable char in the last column of the last row.
    for (int i = 0; i < H - 1; i++) send(8'h78, 24'h000100);
    send(8'h79, 24'h000500);
    chk("pscr_addr", tram_addr, TOTAL - 1);
    chk("pscr_din", tram_din, 32'h00050079);
    count_low(nlow);
    chk("pscr_low", nlow, H + 1);
    chk("pscr_scroll", scroll_offs, H);
    chk("pscr_col", cur_col, 0);

    // Reset in the middle of a full clear.
    send(8'h0C, 24'h000600);
    repeat (50) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("mid_busy", busy, 1);
    #1;
    rst_sys_n = 1'b0;
    exp_q.delete();
    m_col = 0; m_row = 0; m_lb = 0; m_sc = 0;
    #1;
    chk("arst_ready", in_ready, 1);
    chk("arst_we", tram_we, 0);
    chk("arst_addr", tram_addr, 0);
    chk("arst_din", tram_din, 0);
    chk("arst_scroll", scroll_offs, 0);
    chk("arst_busy", busy, 0);
    repeat (3) @(negedge clk_sys);
    rst_sys_n = 1'b1;
    @(negedge clk_sys);
    send(8'h5A, 24'h123400);
    chk("post_addr", tram_addr, 0);
    chk("post_din", tram_din, 32'h1234005A);
    repeat (4) @(negedge clk_sys);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
